// File: rtl/fsm_out_multi.sv
// Multi-channel output-port controller: each channel drains its FIFO in bursts
// headed by the port address, with burst-length limiting and an empty-FIFO watchdog.
module fsm_out_multi #(
  parameter int W_WIDTH   = 8,
  parameter int N_PORTS   = 4,
  parameter int MAX_BURST = 16,
  parameter int WD_LIMIT  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_PORTS*W_WIDTH-1:0]   port_addr,
  input  logic [N_PORTS*W_WIDTH-1:0]   fifo_data,
  input  logic [N_PORTS-1:0]           port_rd,
  input  logic [N_PORTS-1:0]           port_empty,
  output logic [N_PORTS-1:0]           rd_en,
  output logic [N_PORTS*W_WIDTH-1:0]   port_out,
  output logic [N_PORTS-1:0]           port_vld,
  output logic [N_PORTS-1:0]           port_sop,
  output logic [N_PORTS-1:0]           busy,
  output logic [N_PORTS-1:0]           wd_err
);

  localparam int RC_W = $clog2(MAX_BURST + 1);
  localparam int WC_W = $clog2(WD_LIMIT + 1);
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_BURST);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(MAX_BURST - 1);
  localparam logic [WC_W-1:0] WD_LAST = WC_W'(WD_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_ch
    state_t              state_r, state_s;
    logic [RC_W-1:0]     rd_cnt_r, rd_cnt_s;
    logic [WC_W-1:0]     wd_cnt_r, wd_cnt_s;
    logic                rd_go_s;
    logic                start_s;
    logic                wd_fire_s;
    logic                stall_s;
    logic                rd_pend_r;
    logic [W_WIDTH-1:0]  out_r;
    logic                vld_r;
    logic                sop_r;
    logic                err_r;

    assign stall_s = port_rd[g] & port_empty[g];

    // Next-state, read strobe and counter update for this channel
    always_comb begin
      state_s   = state_r;
      rd_cnt_s  = rd_cnt_r;
      wd_cnt_s  = wd_cnt_r;
      rd_go_s   = 1'b0;
      start_s   = 1'b0;
      wd_fire_s = 1'b0;
      case (state_r)
        IDLE: begin
          if (port_rd[g] && !port_empty[g]) begin
            state_s  = BURST;
            start_s  = 1'b1;
            rd_cnt_s = '0;
            wd_cnt_s = '0;
          end else begin
            state_s  = IDLE;
          end
        end
        BURST: begin
          rd_go_s = port_rd[g] & ~port_empty[g] & (rd_cnt_r < RC_MAX);
          if (rd_go_s) begin
            rd_cnt_s = rd_cnt_r + RC_W'(1);
          end else begin
            rd_cnt_s = rd_cnt_r;
          end
          if (stall_s) begin
            wd_cnt_s = wd_cnt_r + WC_W'(1);
          end else begin
            wd_cnt_s = '0;
          end
          // Exit priority: consumer gone, burst complete, then watchdog
          if (!port_rd[g]) begin
            state_s = DRAIN;
          end else if (rd_go_s && (rd_cnt_r == RC_LAST)) begin
            state_s = DRAIN;
          end else if (stall_s && (wd_cnt_r == WD_LAST)) begin
            state_s   = DRAIN;
            wd_fire_s = 1'b1;
          end else begin
            state_s = BURST;
          end
        end
        DRAIN: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end

    // Control state and counters
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_r   <= IDLE;
        rd_cnt_r  <= '0;
        wd_cnt_r  <= '0;
        rd_pend_r <= 1'b0;
        err_r     <= 1'b0;
      end else begin
        state_r   <= state_s;
        rd_cnt_r  <= rd_cnt_s;
        wd_cnt_r  <= wd_cnt_s;
        rd_pend_r <= rd_go_s;
        err_r     <= wd_fire_s;
      end
    end

    // Output word register: header on burst start, otherwise FIFO data one cycle after a read
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_r <= '0;
        vld_r <= 1'b0;
        sop_r <= 1'b0;
      end else if (start_s) begin
        out_r <= port_addr[g*W_WIDTH +: W_WIDTH];
        vld_r <= 1'b1;
        sop_r <= 1'b1;
      end else if (rd_pend_r) begin
        out_r <= fifo_data[g*W_WIDTH +: W_WIDTH];
        vld_r <= 1'b1;
        sop_r <= 1'b0;
      end else begin
        out_r <= out_r;
        vld_r <= 1'b0;
        sop_r <= 1'b0;
      end
    end

    assign rd_en[g]                          = rst_n & rd_go_s;
    assign port_out[g*W_WIDTH +: W_WIDTH]    = out_r;
    assign port_vld[g]                       = vld_r;
    assign port_sop[g]                       = sop_r;
    assign busy[g]                           = (state_r != IDLE);
    assign wd_err[g]                         = err_r;
  end

endmodule

// File: tb/tb_fsm_out_multi.sv
// Bench for fsm_out_multi: FIFO environment plus a timeline-based reference model
// that schedules expected headers and data words by their delivery cycle.
module tb_fsm_out_multi;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 16;
  localparam int WL = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] port_addr;
  logic [N*W-1:0] fifo_data;
  logic [N-1:0]   port_rd;
  logic [N-1:0]   port_empty;
  logic [N-1:0]   rd_en;
  logic [N*W-1:0] port_out;
  logic [N-1:0]   port_vld;
  logic [N-1:0]   port_sop;
  logic [N-1:0]   busy;
  logic [N-1:0]   wd_err;

  always #5 clk = ~clk;

  fsm_out_multi #(.W_WIDTH(W), .N_PORTS(N), .MAX_BURST(MB), .WD_LIMIT(WL)) dut (
    .clk(clk), .rst_n(rst_n), .port_addr(port_addr), .fifo_data(fifo_data),
    .port_rd(port_rd), .port_empty(port_empty), .rd_en(rd_en), .port_out(port_out),
    .port_vld(port_vld), .port_sop(port_sop), .busy(busy), .wd_err(wd_err)
  );

  int ncmp = 0;
  int nfail = 0;

  logic [W-1:0] fifo_q[N][$];
  logic [W-1:0] ref_q[N][$];

  // reference model: phase 0 idle, 1 bursting, 2 draining
  int           phase[N];
  int           nreads[N];
  int           erun[N];
  logic [W-1:0] cur_out[N];
  logic         cur_vld[N], cur_sop[N], cur_err[N];
  logic         due1_v[N], due1_sop[N], due2_v[N];
  logic [W-1:0] due1_d[N], due2_d[N];
  logic [N-1:0] rd_cap, exp_rd, emp_c;

  task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s ch%0d observed=%0h expected=%0h", tag, ch, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [W-1:0] v);
    fifo_q[ch].push_back(v);
    ref_q[ch].push_back(v);
    port_empty[ch] = 1'b0;
  endtask

  task automatic model_step(input int i);
    logic         hdr;
    logic         rdv;
    logic         fire;
    logic [W-1:0] v;
    hdr = 1'b0; rdv = 1'b0; fire = 1'b0; v = '0;
    if (!rst_n) begin
      phase[i] = 0; nreads[i] = 0; erun[i] = 0;
      due1_v[i] = 1'b0; due2_v[i] = 1'b0;
      cur_out[i] = '0; cur_vld[i] = 1'b0; cur_sop[i] = 1'b0; cur_err[i] = 1'b0;
    end else begin
      if (phase[i] == 0) begin
        if (port_rd[i] && !emp_c[i]) begin
          hdr = 1'b1; phase[i] = 1; nreads[i] = 0; erun[i] = 0;
        end
      end else if (phase[i] == 1) begin
        if (exp_rd[i]) begin
          rdv = 1'b1; v = ref_q[i].pop_front(); nreads[i]++;
        end
        if (port_rd[i] && emp_c[i]) erun[i]++;
        else erun[i] = 0;
        if (!port_rd[i]) phase[i] = 2;
        else if (rdv && nreads[i] == MB) phase[i] = 2;
        else if (erun[i] == WL) begin phase[i] = 2; fire = 1'b1; end
      end else begin
        phase[i] = 0;
      end
      if (hdr) begin due1_v[i] = 1'b1; due1_sop[i] = 1'b1; due1_d[i] = port_addr[i*W +: W]; end
      if (rdv) begin due2_v[i] = 1'b1; due2_d[i] = v; end
      cur_err[i] = fire;
      cur_vld[i] = due1_v[i];
      cur_sop[i] = due1_v[i] & due1_sop[i];
      if (due1_v[i]) cur_out[i] = due1_d[i];
      due1_v[i] = due2_v[i]; due1_sop[i] = 1'b0; due1_d[i] = due2_d[i];
      due2_v[i] = 1'b0;
    end
  endtask

  // one clock cycle: check at the falling edge, advance environment and model after the rising edge
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      emp_c[i]  = (ref_q[i].size() == 0);
      exp_rd[i] = rst_n && phase[i] == 1 && port_rd[i] && !emp_c[i] && nreads[i] < MB;
      rd_cap[i] = rd_en[i];
      chk("rd_en",  i, 32'(rd_en[i]),          32'(exp_rd[i]));
      chk("vld",    i, 32'(port_vld[i]),       32'(cur_vld[i]));
      chk("sop",    i, 32'(port_sop[i]),       32'(cur_sop[i]));
      chk("out",    i, 32'(port_out[i*W +: W]), 32'(cur_out[i]));
      chk("busy",   i, 32'(busy[i]),           32'(phase[i] != 0));
      chk("wd_err", i, 32'(wd_err[i]),         32'(cur_err[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd_cap[i] && fifo_q[i].size() != 0) fifo_data[i*W +: W] = fifo_q[i].pop_front();
      model_step(i);
      port_empty[i] = (fifo_q[i].size() == 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; port_rd = '0; port_addr = '0; fifo_data = '0; port_empty = '1;
    for (int i = 0; i < N; i++) begin
      phase[i] = 0; nreads[i] = 0; erun[i] = 0;
      cur_out[i] = '0; cur_vld[i] = 1'b0; cur_sop[i] = 1'b0; cur_err[i] = 1'b0;
      due1_v[i] = 1'b0; due1_sop[i] = 1'b0; due2_v[i] = 1'b0;
      due1_d[i] = '0; due2_d[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst_n = 1'b1;
    tick();

    // three-word burst on ch0, then watchdog abort
    port_addr[0*W +: W] = 8'hA5;
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    port_rd[0] = 1'b1;
    repeat (14) tick();
    port_rd[0] = 1'b0;
    repeat (2) tick();

    // 20 words on ch1: a full 16-word burst then a 4-word burst
    port_addr[1*W +: W] = 8'h3C;
    for (int k = 0; k < 20; k++) push(1, 8'($urandom_range(255)));
    port_rd[1] = 1'b1;
    repeat (40) tick();
    port_rd[1] = 1'b0;
    repeat (2) tick();

    // consumer drops after 5 reads with words still queued
    port_addr[2*W +: W] = 8'h5A;
    for (int k = 0; k < 15; k++) push(2, 8'($urandom_range(255)));
    port_rd[2] = 1'b1;
    repeat (6) tick();
    port_rd[2] = 1'b0;
    repeat (4) tick();

    // 7 empty cycles mid-burst, then refill
    port_addr[3*W +: W] = 8'h77;
    push(3, 8'hC1); push(3, 8'hC2);
    port_rd[3] = 1'b1;
    repeat (10) tick();
    push(3, 8'hD1); push(3, 8'hD2);
    repeat (6) tick();
    port_rd[3] = 1'b0;
    repeat (3) tick();

    // all channels together, with a one-cycle reset mid-burst
    for (int i = 0; i < N; i++) begin
      port_addr[i*W +: W] = 8'(8'h10 + i);
      for (int k = 0; k < 5; k++) push(i, 8'($urandom_range(255)));
    end
    port_rd = '1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    port_rd = '0;
    repeat (3) tick();

    // random traffic
    for (int i = 0; i < N; i++) port_addr[i*W +: W] = 8'($urandom_range(255));
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0 && fifo_q[i].size() < 24) push(i, 8'($urandom_range(255)));
        if ($urandom_range(7) == 0) port_rd[i] = ~port_rd[i];
      end
      rst_n = ($urandom_range(149) != 0);
      tick();
    end
    rst_n = 1'b1;
    port_rd = '0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
